// File: rtl/tt_sweep_capture_if.sv
// Signal bundle between the truth-table sweep harness and whoever drives it
// and hosts the function block under evaluation.
interface tt_sweep_capture_if;
    logic        start;
    logic        abort;
    logic [15:0] expected_tt;
    logic        y0;
    logic        x0;
    logic        x1;
    logic        x2;
    logic        x3;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic [4:0]  ones;
    logic        tt_valid;
    logic        match;

    modport master (
        output start, abort, expected_tt, y0,
        input  x0, x1, x2, x3, busy, done, tt, ones, tt_valid, match
    );

    modport slave (
        input  start, abort, expected_tt, y0,
        output x0, x1, x2, x3, busy, done, tt, ones, tt_valid, match
    );
endinterface

// File: rtl/tt_sweep_capture.sv
// Drives all 16 input vectors into a 4-input function block, samples y0 for
// each, and reports the truth table, its popcount and a compare result.
module tt_sweep_capture #(
    parameter int unsigned SETTLE = 0
) (
    input  logic               clk,
    input  logic               rst,
    tt_sweep_capture_if.slave  bus
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic        abort_s;
    logic        sample_s;
    logic        last_s;

    logic [3:0]  idx_r;
    logic [3:0]  cnt_r;
    logic [3:0]  x_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] tt_r;
    logic [4:0]  ones_r;
    logic        tt_valid_r;
    logic [15:0] exp_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control strobes; abort takes priority over a sample
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        abort_s  = 1'b0;
        sample_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (cnt_r == SETTLE_C) begin
                    sample_s = 1'b1;
                    if (idx_r == 4'd15) begin
                        last_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sweep datapath: vector/settle counters, capture registers and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r      <= 4'd0;
            cnt_r      <= 4'd0;
            x_r        <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tt_r       <= 16'd0;
            ones_r     <= 5'd0;
            tt_valid_r <= 1'b0;
            exp_r      <= 16'd0;
        end else begin
            done_r <= last_s;
            if (accept_s) begin
                exp_r      <= bus.expected_tt;
                tt_r       <= 16'd0;
                ones_r     <= 5'd0;
                tt_valid_r <= 1'b0;
                idx_r      <= 4'd0;
                cnt_r      <= 4'd0;
                x_r        <= 4'd0;
                busy_r     <= 1'b1;
            end else if (abort_s) begin
                idx_r      <= 4'd0;
                cnt_r      <= 4'd0;
                x_r        <= 4'd0;
                busy_r     <= 1'b0;
                tt_valid_r <= 1'b0;
            end else if (sample_s) begin
                tt_r[idx_r] <= bus.y0;
                ones_r      <= ones_r + {4'd0, bus.y0};
                cnt_r       <= 4'd0;
                if (last_s) begin
                    idx_r      <= 4'd0;
                    x_r        <= 4'd0;
                    busy_r     <= 1'b0;
                    tt_valid_r <= 1'b1;
                end else begin
                    idx_r <= idx_r + 4'd1;
                    x_r   <= idx_r + 4'd1;
                end
            end else if (state_r == ST_RUN) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.x0       = x_r[0];
    assign bus.x1       = x_r[1];
    assign bus.x2       = x_r[2];
    assign bus.x3       = x_r[3];
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.tt       = tt_r;
    assign bus.ones     = ones_r;
    assign bus.tt_valid = tt_valid_r;
    assign bus.match    = tt_valid_r && (tt_r == exp_r);

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: one SETTLE=0 and one SETTLE=2 instance, each
// fed by a truth-table model of the function block, checked against spec rules.
module tb_tt_sweep_capture;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_sweep_capture_if bif0 ();
    tt_sweep_capture_if bif2 ();

    tt_sweep_capture #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(bif0));
    tt_sweep_capture #(.SETTLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bif2));

    logic [15:0] tab_s;
    logic        d1_r;
    logic        d2_r;
    logic [3:0]  xv0;
    logic [3:0]  xv2;

    assign xv0 = {bif0.x3, bif0.x2, bif0.x1, bif0.x0};
    assign xv2 = {bif2.x3, bif2.x2, bif2.x1, bif2.x0};

    // Function block models: combinational for dut0, two register stages for dut2
    assign bif0.y0 = tab_s[xv0];
    always @(posedge clk) begin
        d1_r <= tab_s[xv2];
        d2_r <= d1_r;
    end
    assign bif2.y0 = d2_r;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference AIG evaluated directly from its gate equations
    function automatic logic [15:0] aig_table();
        logic [15:0] t;
        logic a, b, c, d, n10, n11;
        for (int i = 0; i < 16; i++) begin
            a = i[0]; b = i[1]; c = i[2]; d = i[3];
            n10 = ~(a & b) & ~(~c & d);
            n11 = ~(c & ~d) & ~(a ^ b);
            t[i] = ~(n10 ^ n11);
        end
        return t;
    endfunction

    task automatic sweep(input logic [15:0] tab, input logic [15:0] exp,
                         input bit abort_with_start, input int restart_at);
        int dc0 = 0, dc2 = 0, nd0 = 0, nd2 = 0, xbad = 0, bbad = 0;
        int e0, e2;
        tab_s = tab;
        @(negedge clk);
        bif0.start = 1'b1; bif2.start = 1'b1;
        bif0.abort = abort_with_start; bif2.abort = abort_with_start;
        bif0.expected_tt = exp; bif2.expected_tt = exp;
        @(posedge clk); #1;
        bif0.start = 1'b0; bif2.start = 1'b0;
        bif0.abort = 1'b0; bif2.abort = 1'b0;
        bif0.expected_tt = ~exp; bif2.expected_tt = ~exp;
        for (int c = 1; c <= 70; c++) begin
            if (c == restart_at) begin
                bif0.start = 1'b1; bif2.start = 1'b1;
            end else begin
                bif0.start = 1'b0; bif2.start = 1'b0;
            end
            if (bif0.done) begin nd0++; dc0 = c; end
            if (bif2.done) begin nd2++; dc2 = c; end
            e0 = (c <= 16) ? c - 1 : 0;
            e2 = (c <= 48) ? (c - 1) / 3 : 0;
            if (int'(xv0) != e0) xbad++;
            if (int'(xv2) != e2) xbad++;
            if (bif0.busy != (c <= 16)) bbad++;
            if (bif2.busy != (c <= 48)) bbad++;
            @(posedge clk); #1;
        end
        bif0.start = 1'b0; bif2.start = 1'b0;
        check("tt0", bif0.tt, tab);
        check("tt2", bif2.tt, tab);
        check("ones0", bif0.ones, $countones(tab));
        check("ones2", bif2.ones, $countones(tab));
        check("valid0", bif0.tt_valid, 1);
        check("valid2", bif2.tt_valid, 1);
        check("match0", bif0.match, tab == exp);
        check("match2", bif2.match, tab == exp);
        check("ndone0", nd0, 1);
        check("ndone2", nd2, 1);
        check("donecyc0", dc0, 17);
        check("donecyc2", dc2, 49);
        check("xseq", xbad, 0);
        check("busyseq", bbad, 0);
    endtask

    task automatic abort_test(input logic [15:0] tab);
        int nd = 0;
        tab_s = tab;
        @(negedge clk);
        bif0.start = 1'b1; bif0.expected_tt = tab;
        @(posedge clk); #1;
        bif0.start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(posedge clk); #1;
        end
        bif0.abort = 1'b1;
        @(posedge clk); #1;
        bif0.abort = 1'b0;
        check("abort_busy", bif0.busy, 0);
        check("abort_valid", bif0.tt_valid, 0);
        check("abort_x", xv0, 0);
        check("abort_match", bif0.match, 0);
        check("abort_partial", bif0.tt & 16'h007F, tab & 16'h007F);
        for (int c = 0; c < 20; c++) begin
            if (bif0.done) nd++;
            @(posedge clk); #1;
        end
        check("abort_nodone", nd, 0);
    endtask

    initial begin
        logic [15:0] aig;
        logic [15:0] rt;
        logic [15:0] re;
        rst = 1'b1;
        bif0.start = 1'b0; bif0.abort = 1'b0; bif0.expected_tt = 16'd0;
        bif2.start = 1'b0; bif2.abort = 1'b0; bif2.expected_tt = 16'd0;
        tab_s = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst0", {bif0.busy, bif0.done, bif0.tt, bif0.ones, bif0.tt_valid, bif0.match, xv0}, 0);
        check("rst2", {bif2.busy, bif2.done, bif2.tt, bif2.ones, bif2.tt_valid, bif2.match, xv2}, 0);
        @(negedge clk); rst = 1'b0;

        aig = aig_table();
        check("aig_ref", aig, 16'h1681);
        sweep(aig, 16'h1681, 1'b0, 0);
        check("aig_ones", bif0.ones, 5);
        sweep(aig, 16'h1680, 1'b0, 0);
        sweep(16'hFFFF, 16'hFFFF, 1'b0, 0);
        check("ones16", bif0.ones, 16);
        sweep(16'h0000, 16'h0000, 1'b0, 0);

        abort_test(aig);
        sweep(aig, 16'h1681, 1'b0, 0);
        sweep(aig, 16'h1681, 1'b0, 5);
        sweep(aig, 16'h1681, 1'b1, 0);

        for (int k = 0; k < 6; k++) begin
            rt = 16'($urandom);
            re = ($urandom_range(0, 1) == 0) ? rt : rt ^ (16'd1 << $urandom_range(0, 15));
            sweep(rt, re, 1'b0, (k % 2 == 0) ? 0 : int'($urandom_range(2, 15)));
        end

        tab_s = 16'hFFFF;
        @(negedge clk);
        bif0.start = 1'b1; bif2.start = 1'b1;
        @(negedge clk);
        bif0.start = 1'b0; bif2.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst0", {bif0.busy, bif0.done, bif0.tt, bif0.ones, bif0.tt_valid, bif0.match, xv0}, 0);
        check("midrst2", {bif2.busy, bif2.done, bif2.tt, bif2.ones, bif2.tt_valid, bif2.match, xv2}, 0);
        @(negedge clk); rst = 1'b0;
        sweep(aig, 16'h1681, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential harness that sits directly upstream and downstream of a 4-input single-output combinational AIG function (inputs x0..x3, output y0).
- On start it drives all 16 input vectors in ascending order and samples y0 for each one.
- It assembles the 16-bit truth table, counts the ones, and compares the table against an expected value.
- Used to characterise and check each generated NPN-class netlist in hardware.

Parameters:
- SETTLE, default 0, extra cycles each vector is held before y0 is sampled; range 0..15. Covers registered or pipelined function blocks.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- expected_tt  input  16  reference truth table; captured on the accepted start.
- y0  input  1  output of the function block under evaluation.
- x0, x1, x2, x3  output  1 each  input vector driven to the function block; idx = {x3,x2,x1,x0}.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes.
- tt  output  16  captured truth table; bit i = y0 sampled for idx i.
- ones  output  5  population count of tt (0..16).
- tt_valid  output  1  tt and ones are from a complete sweep.
- match  output  1  tt_valid and (tt == captured expected_tt).

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; idx=0; settle counter=0; x0..x3=0; busy=0; done=0; tt=0; ones=0; tt_valid=0; match=0; expected register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - x0..x3=0.
  - On start=1: capture expected_tt; clear tt and ones; tt_valid=0; idx=0; cnt=0; go to RUN.
- RUN:
  - busy=1; {x3,x2,x1,x0}=idx, registered.
  - If cnt<SETTLE: cnt++.
  - If cnt==SETTLE: tt[idx]<=y0; ones<=ones+y0; cnt<=0.
  - After sampling, if idx==15 go to DONE; otherwise idx++.
- Timing:
  - Each vector is held SETTLE+1 cycles, and y0 is sampled on the last of those cycles.
  - With start sampled at edge 0, the sweep occupies 16*(SETTLE+1) cycles.
  - done=1 in the cycle after the final sample (cycle 17 when SETTLE=0).
- DONE:
  - done=1 and tt_valid=1 for one cycle; busy=0; then return to IDLE.
  - tt, ones, tt_valid and match hold until the next accepted start or reset.
- match is combinational from registers: tt_valid && tt==expected register.
- start while in RUN or DONE is ignored; expected register is unchanged.
- abort in RUN:
  - Next state IDLE; x=0; busy=0; tt_valid=0; no done pulse.
  - Partial tt remains readable but invalid.
  - abort and start in the same cycle in IDLE: start wins, and abort is ignored outside RUN.
- ones never exceeds 16; a 5-bit register is required and there is no wrap.
- Reset mid-sweep returns everything to the reset values immediately, with no done pulse.

Test Plan:
- SETTLE=0; y0 driven by the reference function n10 XNOR n11, where n10=~(x0&x1)&~(~x2&x3) and n11=~(x2&~x3)&~(x0^x1); expected_tt=16'h1681; pulse start -> done at cycle 17, tt=16'h1681, ones=5, match=1, tt_valid=1.
- Same stimulus with expected_tt=16'h1680 -> tt=16'h1681, match=0.
- SETTLE=2; y0 = function of x delayed by 2 registers; expected 16'h1681 -> each vector held 3 cycles, done at cycle 49, tt=16'h1681, match=1.
- y0 tied to 1 -> tt=16'hFFFF, ones=16. y0 tied to 0 -> tt=0, ones=0.
- abort asserted at cycle 8 of a SETTLE=0 sweep -> busy=0 next cycle, tt_valid=0, no done, x=0; a new start then completes normally.
- start re-pulsed during RUN -> ignored, sweep completes on the original timing. rst asserted mid-sweep -> all outputs 0 immediately.
